// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg
// Shared definitions for the input debouncer slice: parameter defaults
// and the 2-bit FSM state encoding used by the top-level qualifier.
// No ports; imported by input_debouncer.
package input_debouncer_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int GLITCH_W_DEF        = 8;

    // Bit 1 holds the level being tracked, and bit 0 is set while a change
    // is being qualified.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b10,
        CHK_LO    = 2'b11
    } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer
// Multi-flop synchronizer that brings a single asynchronous bit into the
// clk domain. The output is the last flop of the chain.
// Ports:
//   clk - sampling clock, rising edge
//   rst - asynchronous active-low reset, clears the whole chain to 0
//   d   - asynchronous input bit
//   q   - synchronized output, STAGES rising edges behind d
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift register. Bit 0 is the metastability-catching flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer
// Synchronizes a raw switch/pin input and accepts a new level only after it
// has been seen stable for DEBOUNCE_CYCLES+1 consecutive samples. Changes
// that do not survive qualification are counted as glitches.
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   din_async  - raw asynchronous input
//   glitch_clr - synchronous clear of glitch_cnt; it takes priority over an increment
//   d_clean    - registered debounced level
//   busy       - registered; high while a candidate change is being qualified
//   glitch_cnt - saturating count of rejected candidate changes
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GLITCH_W        = GLITCH_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_async,
    input  logic                glitch_clr,
    output logic                d_clean,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int                  CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic             s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             glitch_event;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_async),
        .q   (s)
    );

    // Next-state logic. cnt counts the samples that follow entry into a
    // check state. The candidate level is accepted on the sample where cnt
    // already equals DEBOUNCE_CYCLES-1. That sample is sample
    // DEBOUNCE_CYCLES+1 of the run, counting the entry sample.
    always_comb begin
        next_state   = state;
        cnt_next     = cnt;
        glitch_event = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    next_state = CHK_HI;
                    cnt_next   = '0;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    next_state   = STABLE_LO;
                    cnt_next     = '0;
                    glitch_event = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = STABLE_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    next_state = CHK_LO;
                    cnt_next   = '0;
                end
            end
            CHK_LO: begin
                if (s) begin
                    next_state   = STABLE_HI;
                    cnt_next     = '0;
                    glitch_event = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    next_state = STABLE_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                next_state = STABLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and outputs are registered together. d_clean and busy
    // are decoded from next_state, so they equal a decode of the state
    // register. Because they are flops, they cannot glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= STABLE_LO;
            cnt     <= '0;
            d_clean <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            d_clean <= (next_state == STABLE_HI) || (next_state == CHK_LO);
            busy    <= (next_state == CHK_HI) || (next_state == CHK_LO);
        end
    end

    // Rejected-change counter. It saturates instead of wrapping, and the
    // clear request overrides a simultaneous increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_event && (glitch_cnt != GLITCH_MAX)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
// Scoreboard bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// The stimulus side pushes the expected outputs from a run-length model of
// the debouncing rule. A separate monitor pops and compares every cycle.
module tb_input_debouncer;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int GW   = 8;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_async = 1'b0;
    logic          glitch_clr = 1'b0;
    logic          d_clean;
    logic          busy;
    logic [GW-1:0] glitch_cnt;

    typedef struct packed {
        logic          d;
        logic          b;
        logic [GW-1:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model of the debouncing rule.
    // hist is the input seen through the synchronizer delay.
    // run is the length of the current streak of samples that disagree with
    // the accepted level.
    bit hist[S];
    int run;
    bit m_d;
    int m_g;
    int m_rises = 0;
    int m_falls = 0;

    // Downstream edge-detector view of d_clean.
    int ed_rises = 0;
    int ed_falls = 0;

    input_debouncer #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .GLITCH_W        (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_async  (din_async),
        .glitch_clr (glitch_clr),
        .d_clean    (d_clean),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < S; i++) hist[i] = 1'b0;
        run = 0;
        m_d = 1'b0;
        m_g = 0;
    endtask

    // Drives one cycle of inputs and pushes the outputs expected after the
    // following rising edge.
    // The level is accepted once D+1 consecutive samples disagree with it.
    // A streak that ends early counts as one glitch.
    task automatic applyStimulus(input bit d, input bit clr);
        exp_t e;
        bit   s;
        bit   glitch;
        @(negedge clk);
        din_async  = d;
        glitch_clr = clr;
        s = hist[S-1];
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        glitch = 1'b0;
        if (s != m_d) begin
            run++;
            if (run == D + 1) begin
                m_d = s;
                run = 0;
                if (s) m_rises++;
                else   m_falls++;
            end
        end else begin
            glitch = (run > 0);
            run    = 0;
        end
        if (clr)                      m_g = 0;
        else if (glitch && m_g < GMAX) m_g++;
        e.d = m_d;
        e.b = (run > 0);
        e.g = GW'(m_g);
        exp_q.push_back(e);
    endtask

    // Holds a level and measures, in edges from the first sampling edge,
    // when d_clean reaches that level. It also counts the busy cycles and
    // the d_clean toggles during the hold.
    task automatic holdAndMeasure(input bit level, input int n, input string name);
        int   at      = 0;
        int   busy_n  = 0;
        int   toggles = 0;
        logic prev;
        prev = d_clean;
        for (int k = 1; k <= n; k++) begin
            applyStimulus(level, 1'b0);
            @(posedge clk);
            #2;
            if (at == 0 && d_clean == level) at = k;
            if (busy) busy_n++;
            if (d_clean != prev) toggles++;
            prev = d_clean;
        end
        checkOutput({name, "_latency"}, at, S + D + 1);
        checkOutput({name, "_busy_cycles"}, busy_n, D);
        checkOutput({name, "_toggles"}, toggles, 1);
    endtask

    // Monitor: compares the DUT against the scoreboard after every edge,
    // tracks d_clean edges and checks the spacing between changes.
    initial begin
        exp_t e;
        logic prev_d = 1'b0;
        int   gap    = 1000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                prev_d = 1'b0;
                gap    = 1000;
            end else begin
                gap++;
                if (d_clean != prev_d) begin
                    checkOutput("min_spacing", int'(gap >= D + 1), 1);
                    if (d_clean) ed_rises++;
                    else         ed_falls++;
                    gap = 0;
                end
                prev_d = d_clean;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("d_clean", d_clean, e.d);
                checkOutput("busy", busy, e.b);
                checkOutput("glitch_cnt", glitch_cnt, e.g);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        modelReset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_d_clean", d_clean, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_glitch_cnt", glitch_cnt, 0);
        @(posedge clk);
        #3 rst = 1'b1;

        repeat (3) applyStimulus(1'b0, 1'b0);

        // Clean rise, then clean fall.
        holdAndMeasure(1'b1, 12, "rise");
        holdAndMeasure(1'b0, 12, "fall");

        // A 3-cycle pulse is too short and is rejected as one glitch.
        applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("short_pulse_glitch_cnt", glitch_cnt, 1);
        checkOutput("short_pulse_d_clean", d_clean, 0);
        checkOutput("short_pulse_busy", busy, 0);

        // A bounce burst followed by a steady high.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("bounce_glitch_cnt", glitch_cnt, 2);
        checkOutput("bounce_d_clean", d_clean, 1);
        repeat (12) applyStimulus(1'b0, 1'b0);

        // Drive the glitch counter into saturation, then clear it on the
        // same edge as another glitch.
        applyStimulus(1'b0, 1'b1);
        repeat (300) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        checkOutput("saturated_glitch_cnt", glitch_cnt, GMAX);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("clear_wins_glitch_cnt", glitch_cnt, 0);

        // Assert reset asynchronously while a rise is being qualified.
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_d_clean", d_clean, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_glitch_cnt", glitch_cnt, 0);
        modelReset();
        @(posedge clk);
        #3 rst = 1'b1;
        holdAndMeasure(1'b1, 12, "post_reset_rise");
        repeat (12) applyStimulus(1'b0, 1'b0);

        // Random run lengths with occasional clears.
        repeat (60) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                applyStimulus(lvl, 1'($urandom_range(0, 19) == 0));
            end
        end
        repeat (12) applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        #2;

        checkOutput("edge_rises", ed_rises, m_rises);
        checkOutput("edge_falls", ed_falls, m_falls);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops; legal range 2..4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level; legal range 2..65535.
REQ-003 SHALL have parameter GLITCH_W, default 8: glitch counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset).
REQ-006 SHALL have port din_async, input, 1 bit: raw asynchronous input (switch/pin).
REQ-007 SHALL have port glitch_clr, input, 1 bit: synchronous clear of glitch_cnt.
REQ-008 SHALL have port d_clean, output, 1 bit: registered, debounced level; drives the d input of the downstream edge-detector flop.
REQ-009 SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.
REQ-010 SHALL have port glitch_cnt, output, GLITCH_W bits: count of rejected candidate changes.

Function
REQ-011 SHALL pass din_async through a SYNC_STAGES-flop chain; the last flop output is s.
REQ-012 SHALL implement FSM states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO; d_clean = 1 in STABLE_HI and CHK_LO, else 0, registered.
REQ-013 In STABLE_LO with s=1: go to CHK_HI, cnt<=0; with s=0: stay. STABLE_HI mirrors this with s=0 -> CHK_LO.
REQ-014 In CHK_HI with s=0: return to STABLE_LO, glitch_cnt increments; with s=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI; otherwise cnt<=cnt+1. CHK_LO mirrors this.
REQ-015 cnt SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and never exceed DEBOUNCE_CYCLES-1.
REQ-016 Latency: a din_async change held stable SHALL appear on d_clean exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples it.
REQ-017 A pulse of din_async shorter than DEBOUNCE_CYCLES+1 cycles (as seen at s) SHALL NOT change d_clean.
REQ-018 busy SHALL be 1 exactly in CHK_HI and CHK_LO.
REQ-019 glitch_cnt SHALL saturate at 2^GLITCH_W-1 and not wrap.
REQ-020 On glitch_clr=1, glitch_cnt<=0; if it coincides with a glitch increment, clear wins.
REQ-021 d_clean SHALL change at most once per DEBOUNCE_CYCLES+1 cycles; it SHALL not glitch combinationally.

Reset
REQ-022 rst=0 SHALL asynchronously force sync chain to 0, state STABLE_LO, cnt 0, d_clean 0, busy 0, glitch_cnt 0.
REQ-023 Reset asserted mid-qualification SHALL abort it with no glitch_cnt change; after release, a din_async held at 1 SHALL be qualified normally (d_clean rises after REQ-016 latency).
REQ-024 Reset deassertion SHALL need no synchronous settling beyond the sync chain; first active edge is the first edge with rst=1.

Structure
REQ-025 SHALL place the FSM state enum (2-bit encoding) and parameter defaults in shared package input_debouncer_pkg.
REQ-026 SHALL instantiate one sub-module, bit_synchronizer (parameter STAGES, ports clk, rst, d, q, async active-low reset to 0), for the sync chain.
REQ-027 SHALL contain no latches and no combinational path from din_async to any output.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-028 Reset then din_async 0->1 held -> d_clean rises exactly 7 edges after first sampling edge; busy high for the 4 preceding cycles.
REQ-029 din_async high for 3 cycles then low -> d_clean stays 0, glitch_cnt = 1, busy returns 0.
REQ-030 Bounce burst 1,0,1,0,1 (1 cycle each) then hold 1 -> glitch_cnt = 2, d_clean rises once, no spurious toggle.
REQ-031 Force 300 rejected glitches with GLITCH_W=8 -> glitch_cnt holds 255; glitch_clr on same cycle as a glitch -> 0.
REQ-032 rst pulsed low during CHK_HI -> all outputs 0 immediately (asynchronously); with din_async still 1, d_clean rises 7 edges after release.
REQ-033 Stable 1 then 0 held -> d_clean falls after 7 edges; a downstream edge-detector flop sees exactly one rise and one fall.
